// File: rtl/mmio_io_controller_if.sv
// ----------------------------------------------------------------------------
// mmio_io_controller_if
// Purpose : CPU-side load/store bus of the memory-mapped IO block. The CPU
//           address decode drives it (master); the IO block answers it (slave).
// Signals : sel          block selected by the top-level address decode
//           address      byte address within the block (word index = [5:2])
//           mem_mode     access size: byte / half / word (other codes = word)
//           mem_unsigned zero-extend sub-word loads when high
//           wren         write strobe, qualified by sel
//           data         store data, right-aligned
//           q            load data, valid the cycle after the address
//           misaligned   one-cycle pulse after a rejected misaligned access
// ----------------------------------------------------------------------------
interface mmio_io_controller_if;
   logic        sel;
   logic [5:0]  address;
   logic [1:0]  mem_mode;
   logic        mem_unsigned;
   logic        wren;
   logic [31:0] data;
   logic [31:0] q;
   logic        misaligned;

   // The CPU side drives requests and receives load data and the error pulse
   modport master (
      output sel, address, mem_mode, mem_unsigned, wren, data,
      input  q, misaligned
   );

   // The IO block receives requests and returns load data and the error pulse
   modport slave (
      input  sel, address, mem_mode, mem_unsigned, wren, data,
      output q, misaligned
   );
endinterface

// File: rtl/mmio_io_controller.sv
// ----------------------------------------------------------------------------
// mmio_io_controller
// Purpose : Memory-mapped IO block for the RV32I data address space. Provides
//           NUM_OUT byte-writable 32-bit output words and NUM_IN debounced
//           inputs with sticky rising-edge flags and a level interrupt.
//           Register map (word index): 0 IN_LEVEL (RO), 1 IN_EDGE (W1C),
//           2 IRQ_EN (RW), 3 reserved, 4.. OUT[k] (RW).
// Ports   : clock          system clock, rising edge
//           reset          asynchronous, active-high
//           bus            CPU load/store bus (slave side)
//           io_input_bus   raw asynchronous inputs
//           io_output_bus  OUT[k] on bits [32k+31:32k]
//           irq            |(IN_EDGE & IRQ_EN), registered
// ----------------------------------------------------------------------------
module mmio_io_controller #(
   parameter int NUM_OUT         = 2,
   parameter int NUM_IN          = 14,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   mmio_io_controller_if.slave    bus,
   input  logic [NUM_IN-1:0]      io_input_bus,
   output logic [32*NUM_OUT-1:0]  io_output_bus,
   output logic                   irq
);

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } memMode_e;

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [31:0]       outRegs_q [NUM_OUT];
   logic [31:0]       outRegs_d [NUM_OUT];
   logic [NUM_IN-1:0] irqEn_q, irqEn_d;
   logic [NUM_IN-1:0] inEdge_q, inEdge_d;
   logic [NUM_IN-1:0] level_q, level_d;
   logic [NUM_IN-1:0] sync1_q, sync2_q;
   logic [CNT_W-1:0]  cnt_q [NUM_IN];
   logic [CNT_W-1:0]  cnt_d [NUM_IN];
   logic [31:0]       readData_q, readData_d;
   logic              misaligned_q;
   logic              irq_q, irq_d;

   logic [3:0]        wordIdx;
   logic [1:0]        byteOff;
   logic [3:0]        laneEn;
   logic [31:0]       bitMask;
   logic [31:0]       wrBits;
   logic              misalignedNow;
   logic              writeOk;
   logic [NUM_IN-1:0] edgeSet, edgeClear;
   logic [31:0]       rdWord, rdShift, rdExt;

   assign wordIdx = bus.address[5:2];
   assign byteOff = bus.address[1:0];

   // Decode the access size into byte-lane enables and flag accesses that
   // would straddle the word boundary; only a selected access can be rejected.
   always_comb begin
      laneEn        = 4'b0000;
      misalignedNow = 1'b0;
      case (memMode_e'(bus.mem_mode))
         MEM_BYTE: laneEn = 4'b0001 << byteOff;
         MEM_HALF: begin
            laneEn        = 4'b0011 << byteOff;
            misalignedNow = (byteOff == 2'd3);
         end
         default: begin
            laneEn        = 4'b1111;
            misalignedNow = (byteOff != 2'd0);
         end
      endcase
      misalignedNow = misalignedNow & bus.sel;
   end

   // Expand lane enables to a bit mask and line the store data up with its lanes
   always_comb begin
      bitMask = '0;
      for (int i = 0; i < 32; i++) begin
         bitMask[i] = laneEn[i/8];
      end
      wrBits = (bus.data << {byteOff, 3'b000}) & bitMask;
   end

   assign writeOk = bus.sel & bus.wren & ~misalignedNow;

   // Register writes: IRQ_EN and OUT words merge the enabled lanes, while a
   // one written to an IN_EDGE lane becomes a clear request for that flag.
   always_comb begin
      outRegs_d = outRegs_q;
      irqEn_d   = irqEn_q;
      edgeClear = '0;
      if (writeOk) begin
         if (wordIdx == 4'd1) begin
            edgeClear = wrBits[NUM_IN-1:0];
         end
         if (wordIdx == 4'd2) begin
            irqEn_d = (irqEn_q & ~bitMask[NUM_IN-1:0]) | wrBits[NUM_IN-1:0];
         end
         for (int k = 0; k < NUM_OUT; k++) begin
            if (wordIdx == 4'(4 + k)) begin
               outRegs_d[k] = (outRegs_q[k] & ~bitMask) | wrBits;
            end
         end
      end
   end

   // Debounce: a channel's counter runs only while the synchronised input
   // disagrees with the accepted level, and the level flips on the cycle the
   // run reaches DEBOUNCE_CYCLES. The counter therefore never exceeds
   // DEBOUNCE_CYCLES-1 and cannot wrap. A new rising level sets the sticky
   // flag; setting it beats a simultaneous clear.
   always_comb begin
      level_d = level_q;
      for (int i = 0; i < NUM_IN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               level_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      edgeSet  = level_d & ~level_q;
      inEdge_d = (inEdge_q & ~edgeClear) | edgeSet;
      irq_d    = |(inEdge_q & irqEn_q);
   end

   // Read path works on the register contents before this edge's write, so a
   // read-during-write returns the old value. The word is shifted down to the
   // addressed byte, then sign- or zero-extended for sub-word loads.
   always_comb begin
      rdWord = '0;
      case (wordIdx)
         4'd0:    rdWord = 32'(level_q);
         4'd1:    rdWord = 32'(inEdge_q);
         4'd2:    rdWord = 32'(irqEn_q);
         default: rdWord = '0;
      endcase
      for (int k = 0; k < NUM_OUT; k++) begin
         if (wordIdx == 4'(4 + k)) begin
            rdWord = outRegs_q[k];
         end
      end
      rdShift = rdWord >> {byteOff, 3'b000};
      case (memMode_e'(bus.mem_mode))
         MEM_BYTE: rdExt = {{24{~bus.mem_unsigned & rdShift[7]}}, rdShift[7:0]};
         MEM_HALF: rdExt = {{16{~bus.mem_unsigned & rdShift[15]}}, rdShift[15:0]};
         default:  rdExt = rdShift;
      endcase
      readData_d = (bus.sel && !misalignedNow) ? rdExt : '0;
   end

   // All state lives here; reset clears everything, including in-flight reads
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            outRegs_q[k] <= '0;
         end
         for (int i = 0; i < NUM_IN; i++) begin
            cnt_q[i] <= '0;
         end
         irqEn_q      <= '0;
         inEdge_q     <= '0;
         level_q      <= '0;
         sync1_q      <= '0;
         sync2_q      <= '0;
         readData_q   <= '0;
         misaligned_q <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         outRegs_q    <= outRegs_d;
         cnt_q        <= cnt_d;
         irqEn_q      <= irqEn_d;
         inEdge_q     <= inEdge_d;
         level_q      <= level_d;
         sync1_q      <= io_input_bus;
         sync2_q      <= sync1_q;
         readData_q   <= readData_d;
         misaligned_q <= misalignedNow;
         irq_q        <= irq_d;
      end
   end

   for (genvar k = 0; k < NUM_OUT; k++) begin : gOut
      assign io_output_bus[32*k +: 32] = outRegs_q[k];
   end

   assign bus.q          = readData_q;
   assign bus.misaligned = misaligned_q;
   assign irq            = irq_q;

endmodule
